mem_access_stage: RTL

//  MEM-stage data-memory access unit; consumes the EX/MEM latch outputs and feeds the MEM/WB latch.

---
 rtl/mem_access_stage.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit on a req/ready + rvalid data bus.
// Optional misalignment trap: define MEM_MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUO_MEM,
  input  logic [31:0] Datao_MEM,
  input  logic        WR_MEM,
  input  logic        mem_r_MEM,
  input  logic [2:0]  u_b_h_w_MEM,
  input  logic        isFlushed,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data,
  output logic        stall_mem,
  output logic        ld_misalign,
  output logic        st_misalign,
  output logic        bus_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST =
    WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic           access;
  logic           is_b, is_h, is_w;
  logic           misal;
  logic [1:0]     a_lo;
  logic [3:0]     be_nx;
  logic [31:0]    wdata_nx;
  logic           we_q;
  logic [2:0]     wid_q;
  logic [1:0]     lo_q;
  logic [WDW-1:0] wd;
  logic           wd_hit;
  logic           req_fin;
  logic [31:0]    rd_sh;
  logic [31:0]    ld_ext;

  assign access = (WR_MEM | mem_r_MEM) & ~isFlushed;

  always_comb begin
    is_b = 1'b0;
    is_h = 1'b0;
    is_w = 1'b0;
    unique case (1'b1)
      (u_b_h_w_MEM[1:0] == 2'b00): is_b = 1'b1;
      (u_b_h_w_MEM[1:0] == 2'b01): is_h = 1'b1;
      default:                     is_w = 1'b1;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misal = (is_h & ALUO_MEM[0])
               | (is_w & (|ALUO_MEM[1:0]));
  assign a_lo  = ALUO_MEM[1:0];
`else
  assign misal = 1'b0;
  // Silently realign: the bus only ever sees naturally aligned lanes.
  assign a_lo  = is_w ? 2'b00
               : is_h ? {ALUO_MEM[1], 1'b0}
               : ALUO_MEM[1:0];
`endif

  always_comb begin
    be_nx    = 4'b1111;
    wdata_nx = Datao_MEM;
    if (is_b) begin
      be_nx    = 4'b0001 << a_lo;
      wdata_nx = {4{Datao_MEM[7:0]}};
    end else if (is_h) begin
      be_nx    = 4'b0011 << {a_lo[1], 1'b0};
      wdata_nx = {2{Datao_MEM[15:0]}};
    end
  end

  assign rd_sh = dmem_rdata >> {lo_q, 3'b000};

  always_comb begin
    ld_ext = rd_sh;
    case (wid_q)
      3'b000:  ld_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
      3'b001:  ld_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
      3'b100:  ld_ext = {24'd0, rd_sh[7:0]};
      3'b101:  ld_ext = {16'd0, rd_sh[15:0]};
      default: ld_ext = rd_sh;
    endcase
  end

  assign stall_mem = ((state == IDLE) & access)
                   | (state == REQ)
                   | (state == RESP);

  assign wd_hit  = (wd == WD_LAST);
  assign req_fin = dmem_ready & (we_q | dmem_rvalid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (access) state_nx = misal ? DONE : REQ;
      end
      REQ: begin
        if (req_fin | wd_hit)  state_nx = DONE;
        else if (dmem_ready)   state_nx = RESP;
      end
      RESP: begin
        if (dmem_rvalid | wd_hit) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_be     <= '0;
      load_data   <= '0;
      ld_misalign <= 1'b0;
      st_misalign <= 1'b0;
      bus_err     <= 1'b0;
      we_q        <= 1'b0;
      wid_q       <= '0;
      lo_q        <= '0;
      wd          <= '0;
    end else begin
      ld_misalign <= 1'b0;
      st_misalign <= 1'b0;
      bus_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            wd <= '0;
            if (misal) begin
              st_misalign <= WR_MEM;
              ld_misalign <= ~WR_MEM;
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= WR_MEM;
              dmem_addr  <= {ALUO_MEM[31:2], 2'b00};
              dmem_be    <= be_nx;
              dmem_wdata <= wdata_nx;
              we_q       <= WR_MEM;
              wid_q      <= u_b_h_w_MEM;
              lo_q       <= a_lo;
            end
          end
        end
        REQ: begin
          if (req_fin) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (!we_q) load_data <= ld_ext;
          end else if (wd_hit) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
            if (dmem_ready) begin
              dmem_req <= 1'b0;
              dmem_we  <= 1'b0;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) load_data <= ld_ext;
          else if (wd_hit) bus_err <= 1'b1;
          else             wd <= wd + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
